// File: rtl/masked_pkg.sv
// masked_pkg: shared state encoding and counter sizing for the share recombiner.
package masked_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} rsm_state_t;
  function automatic int share_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/share_xor_acc.sv
// share_xor_acc: XOR accumulator and share counter; o_full flags the share that completes a frame by count.
module share_xor_acc
  import masked_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NSHARES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_acc,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_share,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_full
);
  localparam int CW = share_cnt_w(NSHARES);
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  always_comb begin
    o_sum  = (i_load ? '0 : r_acc) ^ i_share;
    o_full = r_cnt == CW'(NSHARES - 1);
  end
  // clear wins so the recombined value never lingers in acc
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= i_share;
      r_cnt <= CW'(1);
    end else if (i_acc) begin
      r_acc <= o_sum;
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/masked_share_recombiner.sv
// masked_share_recombiner: XOR-recombines NSHARES Boolean shares per frame into the plain value.
// Optional in_last framing check enabled by defining LAST_CHECK_EN.
module masked_share_recombiner
  import masked_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NSHARES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_share,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);
  if (NSHARES < 2) begin : g_bad_nshares
    $error("NSHARES must be >= 2");
  end
  rsm_state_t       r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic             w_accept;
  logic             w_full;
  logic             w_done;
  logic             w_err;
  logic             w_fin;
  logic [WIDTH-1:0] w_sum;
  always_comb begin
    in_ready = (r_state == HOLD) ? out_ready : 1'b1;
    w_accept = in_valid && in_ready;
`ifdef LAST_CHECK_EN
    w_done = w_full || in_last;
    w_err  = w_full ^ in_last;
`else
    w_done = w_full;
    w_err  = 1'b0;
`endif
    w_fin = w_accept && w_done;
  end
`ifndef LAST_CHECK_EN
  logic w_unused_last;
  assign w_unused_last = in_last;
`endif
  share_xor_acc #(.WIDTH(WIDTH), .NSHARES(NSHARES)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept && r_state != ACCUM),
    .i_acc   (w_accept && r_state == ACCUM),
    .i_clear (w_fin),
    .i_share (in_share),
    .o_sum   (w_sum),
    .o_full  (w_full)
  );
  // HOLD only moves on an output handshake; a new first share may ride along with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (r_state != HOLD || out_ready) begin
      if (w_fin) begin
        r_state     <= HOLD;
        r_out_valid <= 1'b1;
        r_out_data  <= w_sum;
        r_out_err   <= w_err;
      end else begin
        r_state     <= w_accept ? ACCUM : (r_state == HOLD ? IDLE : r_state);
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_err   <= 1'b0;
      end
    end
  end
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
endmodule

// File: doc/masked_share_recombiner.md
Name: masked_share_recombiner

Overview:
- Sequential unmasking block. It is the inverse end of share generation: it takes NSHARES Boolean shares of a WIDTH-bit value, one share per cycle over a valid/ready stream, and XOR-recombines them into the plain value.
- Sits at the exit of the masked datapath, after the masked adder. It is the only point where unmasked data reappears.

Parameters:
- WIDTH, 64, bit width of each share and of the recombined value.
- NSHARES, 3, shares per frame; must be >= 2, checked by elaboration assertion.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  share present on in_share.
- in_ready  output  1  block can accept a share this cycle.
- in_share  input  WIDTH  one Boolean share.
- in_last  input  1  sender marks final share of frame; used only under LAST_CHECK_EN.
- out_valid  output  1  recombined value present.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  XOR of all shares of the frame; 0 whenever out_valid=0.
- out_err  output  1  frame framing error; qualified by out_valid; 0 without LAST_CHECK_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_err=0. in_ready is 1 combinationally after reset.
- Input handshake: a share is accepted when in_valid && in_ready. in_share and in_last are sampled only on accept.
- States:
  - IDLE: in_ready=1. On accept: acc<=in_share, cnt<=1, go to ACCUM.
  - ACCUM: in_ready=1. On accept: acc<=acc^in_share, cnt<=cnt+1. If cnt==NSHARES-1 at accept: load the output register with acc^in_share, set out_valid<=1, clear acc<=0 and cnt<=0, go to HOLD.
  - HOLD: out_valid=1, out_data stable until handshake. in_ready=out_ready (combinational) so the pipeline can keep moving.
    - If out_ready and no accept: out_valid<=0, out_data<=0, go to IDLE.
    - If out_ready and accept in the same cycle: output handshake completes, acc<=in_share, cnt<=1, go to ACCUM.
- Latency: out_valid rises on the clock edge that accepts the NSHARES-th share. Data is visible the cycle after that accept.
- Throughput: one frame per NSHARES cycles with no bubbles, provided out_ready stays high.
- cnt width is $clog2(NSHARES+1). cnt never exceeds NSHARES-1.
- Idle input: in_valid=0 in any state holds acc and cnt; there is no timeout.
- Zeroization: after the output handshake, out_data is driven 0. After the last-share recombination, acc is cleared to 0. No residual plain value stays in a register.
- Reset mid-frame: partial shares are discarded, state goes to IDLE, and out_valid drops on the same edge.
- out_data, out_valid and out_err are registered outputs. in_ready is combinational from state and out_ready.

Optional Feature:
- LAST_CHECK_EN defined:
  - in_last is checked on every accept.
  - in_last=1 with cnt<NSHARES-1 is an early termination. The frame completes immediately with out_data=acc^in_share and out_err=1, and the state goes to HOLD.
  - in_last=0 on the NSHARES-th share completes the frame normally with out_err=1.
  - Correct framing gives out_err=0.
  - out_err is cleared together with out_valid.
- LAST_CHECK_EN undefined: in_last is ignored, out_err is tied to 0, and frames are delimited purely by count.

Decomposition:
- Package masked_pkg:
  - state enum typedef rsm_state_t {IDLE, ACCUM, HOLD}.
  - function share_cnt_w(NSHARES) returning $clog2(NSHARES+1).
- One sub-module, share_xor_acc. It holds the acc register, the cnt counter and the done flag, with inputs load/accumulate/clear/share.
- The top-level module holds the FSM, the output register and the handshake logic.

Test Plan (WIDTH=8, NSHARES=3):
- Basic recombination: shares 0x5A, 0x3C, 0x0F with out_ready=1 → out_valid one cycle after the third accept, out_data=0x69, out_err=0. Next cycle out_valid=0 and out_data=0x00.
- Backpressure: same frame with out_ready=0 for 5 cycles → out_data holds 0x69, in_ready=0 throughout. out_ready=1 completes the handshake, then out_data=0x00.
- Back-to-back: frame A (0x01, 0x02, 0x04) then frame B (0xFF, 0x0F, 0xF0), in_valid and out_ready held at 1 → outputs 0x07 then 0x00. The first share of B is accepted in the same cycle as A's output handshake.
- Reset mid-frame: accept 0xAA and 0x55, assert rst for one cycle, then send 0x10, 0x20, 0x40 → out_data=0x70. No output for the aborted frame.
- Stalled input: 0x11, two idle cycles, 0x22, one idle cycle, 0x44 → out_data=0x77. cnt holds value across gaps.
- LAST_CHECK_EN: in_last=1 on the second share (0x11, 0x22) → out_data=0x33, out_err=1. A following correct frame (0x01, 0x02, 0x04 with last on the third share) → out_data=0x07, out_err=0.
